// File: rtl/aes_inv_key_sched.sv
`timescale 1ns/1ps
// Purpose: regenerates AES-128 round keys 10 down to 0 by running the key expansion backwards.
// Latency: round 10 is valid the cycle after start; each later round is valid 4 cycles after the previous handshake.
// Backpressure: rk_ready low holds round_key/round_idx/rk_valid stable in PRESENT with no state change.
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] r0_q, r1_q, r2_q, r3_q;
    logic [5:0]  j_q;
    logic [1:0]  sub_q;
    logic [3:0]  idx_q;
    logic        vld_q;
    logic        busy_q;

    logic [7:0]  rcon_b;
    logic [31:0] temp_w;
    logic [31:0] new_w;

    // Round constant for the round being left; index is j/4 at the j = 4r step.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Recover w[j-4] = w[j] ^ T(w[j-1]); the S-box path is only used on the j = 4r step.
    always_comb begin
        sbox_in = {r2_q[23:0], r2_q[31:24]};
        rcon_b  = rcon(j_q[5:2]);
        if (j_q[1:0] == 2'd0) begin
            temp_w = sbox_out ^ {rcon_b, 24'h000000};
        end else begin
            temp_w = r2_q;
        end
        new_w = r3_q ^ temp_w;
    end

    // Control FSM and window shift register; all outputs are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            r0_q    <= 32'h0;
            r1_q    <= 32'h0;
            r2_q    <= 32'h0;
            r3_q    <= 32'h0;
            j_q     <= 6'd0;
            sub_q   <= 2'd0;
            idx_q   <= 4'd0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        r0_q    <= last_key[127:96];
                        r1_q    <= last_key[95:64];
                        r2_q    <= last_key[63:32];
                        r3_q    <= last_key[31:0];
                        j_q     <= 6'd43;
                        idx_q   <= 4'd10;
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (rk_ready) begin
                        vld_q <= 1'b0;
                        if (idx_q == 4'd0) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            sub_q   <= 2'd0;
                            state_q <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    r3_q  <= r2_q;
                    r2_q  <= r1_q;
                    r1_q  <= r0_q;
                    r0_q  <= new_w;
                    j_q   <= j_q - 6'd1;
                    sub_q <= sub_q + 2'd1;
                    if (sub_q == 2'd3) begin
                        idx_q   <= idx_q - 4'd1;
                        vld_q   <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign round_key = {r0_q, r1_q, r2_q, r3_q};
    assign round_idx = idx_q;
    assign rk_valid  = vld_q;
    assign busy      = busy_q;

endmodule
